fft_addr_gen: RTL and testbench

Control and address generator for an in-place radix-2 decimation-in-time FFT built around the butterfly unit (BFU). For each butterfly it issues the A/B operand read addresses of the sample memory and the twiddle-ROM index that the BFU's twiddleF_r/twiddleF_i inputs are fetched from. It also produces the write-back addresses and enable, delayed to line up with the BFU results, and sequences all log2(N) stages from a single start pulse.

---
 rtl/fft_addr_gen_if.sv | 29 ++
 rtl/fft_addr_gen.sv | 157 +++++++++++++++
 tb/tb_fft_addr_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_addr_gen_if.sv
// Bus between the FFT address generator and the memory/BFU datapath.
// The generator side uses the master modport.
interface fft_addr_gen_if #(
    parameter int LOG2N = 4
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_valid;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [3:0]       stage;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_idx, stage,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_idx, stage,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Read/write address and twiddle-index sequencer for an in-place radix-2 DIT FFT.
// state | meaning: IDLE wait start | RUN one butterfly/cycle | FLUSH drain BFU pipe | DONE pulse done
module fft_addr_gen #(
    parameter int LOG2N    = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fft_addr_gen_if.master bus
);
    localparam int KW = LOG2N - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [KW-1:0]    K_LAST     = '1;
    localparam logic [KW-1:0]    K_ONE      = KW'(1);
    localparam logic [LOG2N-1:0] A_ONE      = LOG2N'(1);
    localparam logic [2:0]       FLUSH_INIT = 3'(PIPE_LAT - 1);
    localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);
    localparam logic [3:0]       TW_SH_MAX  = 4'(KW);

    typedef struct packed {
        logic             v;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } dl_t;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0]    stage_q, stage_d;
    logic [2:0]    cnt_q, cnt_d;

    logic             busy_q, done_q, rv_q;
    logic [LOG2N-1:0] addr_a_q, addr_b_q;
    logic [KW-1:0]    tw_q;
    logic [3:0]       stage_out_q;
    dl_t              dl_q [PIPE_LAT];

    logic [LOG2N-1:0] k_ext, span, pos, base, tw_full;
    logic [LOG2N-1:0] addr_a_d, addr_b_d;
    logic [KW-1:0]    tw_d;
    logic [3:0]       tw_sh;
    logic             run_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 3'd0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage_q + 4'd1;
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        run_d    = (state_d == S_RUN);
        k_ext    = {1'b0, k_d};
        span     = A_ONE << stage_d;
        pos      = k_ext & (span - A_ONE);
        base     = (k_ext >> stage_d) << (stage_d + 4'd1);
        tw_sh    = TW_SH_MAX - stage_d;
        tw_full  = pos << tw_sh;
        addr_a_d = '0;
        addr_b_d = '0;
        tw_d     = '0;
        if (run_d) begin
            addr_a_d = base | pos;
            addr_b_d = (base | pos) + span;
            tw_d     = tw_full[KW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            stage_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rv_q        <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            tw_q        <= '0;
            stage_out_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d == S_RUN) || (state_d == S_FLUSH);
            done_q      <= (state_d == S_DONE);
            rv_q        <= run_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            tw_q        <= tw_d;
            stage_out_q <= run_d ? stage_d : 4'd0;
        end
    end

    // Delay line free-runs; clearing it on reset kills stale write-backs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= '{v: rv_q, a: addr_a_q, b: addr_b_q};
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_valid  = rv_q;
    assign bus.rd_addr_a = addr_a_q;
    assign bus.rd_addr_b = addr_b_q;
    assign bus.tw_idx    = tw_q;
    assign bus.stage     = stage_out_q;
    assign bus.wr_en     = dl_q[PIPE_LAT-1].v;
    assign bus.wr_addr_a = dl_q[PIPE_LAT-1].a;
    assign bus.wr_addr_b = dl_q[PIPE_LAT-1].b;
endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: LOG2N=4/P=2 instance for timeline, spot, restart and reset
// checks, plus a LOG2N=3/P=1 instance for the parameter sweep.
module tb_fft_addr_gen;
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rv;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] tw;
        logic [3:0]  st;
        logic        we;
        logic [15:0] wa;
        logic [15:0] wb;
    } obs_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fft_addr_gen_if #(.LOG2N(4)) bus0 ();
    fft_addr_gen_if #(.LOG2N(3)) bus1 ();

    fft_addr_gen #(.LOG2N(4), .PIPE_LAT(2)) dut0 (.clk_i(clk), .rst_i(rst0), .bus(bus0));
    fft_addr_gen #(.LOG2N(3), .PIPE_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));

    // Read-side reference: which butterfly (if any) is issued in cycle c after start.
    function automatic obs_t rd_info(input int lg, input int p, input int c);
        obs_t r;
        int h, t, s, j, span;
        r = '0;
        h = (1 << lg) / 2;
        t = h + p;
        if (c >= 1 && c <= lg * t) begin
            s = (c - 1) / t;
            j = (c - 1) % t;
            if (j < h) begin
                span = 2 ** s;
                r.rv = 1'b1;
                r.a  = 16'((j / span) * 2 * span + (j % span));
                r.b  = 16'((j / span) * 2 * span + (j % span) + span);
                r.tw = 16'((j % span) * (h / span));
                r.st = 4'(s);
            end
        end
        return r;
    endfunction

    function automatic obs_t model(input int lg, input int p, input int c);
        obs_t r, w;
        int lt;
        lt   = lg * ((1 << lg) / 2 + p);
        r    = rd_info(lg, p, c);
        w    = rd_info(lg, p, c - p);
        r.we = w.rv;
        r.wa = w.a;
        r.wb = w.b;
        r.busy = (c >= 1 && c <= lt);
        r.done = (c == lt + 1);
        return r;
    endfunction

    function automatic obs_t obs0();
        obs_t r;
        r.busy = bus0.busy;  r.done = bus0.done;  r.rv = bus0.rd_valid;
        r.a  = 16'(bus0.rd_addr_a);  r.b  = 16'(bus0.rd_addr_b);
        r.tw = 16'(bus0.tw_idx);     r.st = bus0.stage;
        r.we = bus0.wr_en;
        r.wa = 16'(bus0.wr_addr_a);  r.wb = 16'(bus0.wr_addr_b);
        return r;
    endfunction

    function automatic obs_t obs1();
        obs_t r;
        r.busy = bus1.busy;  r.done = bus1.done;  r.rv = bus1.rd_valid;
        r.a  = 16'(bus1.rd_addr_a);  r.b  = 16'(bus1.rd_addr_b);
        r.tw = 16'(bus1.tw_idx);     r.st = bus1.stage;
        r.we = bus1.wr_en;
        r.wa = 16'(bus1.wr_addr_a);  r.wb = 16'(bus1.wr_addr_b);
        return r;
    endfunction

    task automatic chk(input string tag, input int c, input obs_t got, input obs_t exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h required %h", tag, c, got, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spot-check table: cycle of the butterfly and its expected a/b/tw.
    int sp_c  [4] = '{1, 14, 26, 38};
    int sp_a  [4] = '{0, 5, 9, 7};
    int sp_b  [4] = '{1, 7, 13, 15};
    int sp_tw [4] = '{0, 4, 2, 7};

    // mode 0: no extra start, 1: start pulses at cycles 5 and 41, 2: random start noise.
    task automatic run_full0(input int mode);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            chk("timeline", c, obs0(), model(4, 2, c));
            for (int i = 0; i < 4; i++) begin
                if (c == sp_c[i])
                    chk_val("spot_rd", {bus0.rd_addr_a, bus0.rd_addr_b, bus0.tw_idx},
                            {4'(sp_a[i]), 4'(sp_b[i]), 3'(sp_tw[i])});
                if (c == sp_c[i] + 2)
                    chk_val("spot_wr", {bus0.wr_en, bus0.wr_addr_a, bus0.wr_addr_b},
                            {1'b1, 4'(sp_a[i]), 4'(sp_b[i])});
            end
            if (mode == 1)      bus0.start = (c == 5 || c == 41);
            else if (mode == 2) bus0.start = 1'($urandom_range(0, 1));
            tick();
        end
        bus0.start = 1'b0;
    endtask

    task automatic idle0(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            chk(tag, i, obs0(), model(4, 2, -100));
            tick();
        end
    endtask

    initial begin
        int gap;
        logic [7:0] mask [3];
        int         cnt  [3];

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", i, obs0(), model(4, 2, -100));
        end
        rst0 = 1'b0;
        idle0(20, "idle");

        run_full0(0);
        idle0(3, "post_done");

        run_full0(1);
        run_full0(0);
        idle0(2, "post_restart");

        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk("pre_reset", c, obs0(), model(4, 2, c));
            if (c == 12) rst0 = 1'b1;
            tick();
        end
        rst0 = 1'b0;
        idle0(15, "after_reset");
        run_full0(0);
        idle0(2, "after_reset_run");

        repeat (3) begin
            gap = int'($urandom_range(0, 4));
            idle0(gap + 1, "rand_gap");
            run_full0(2);
        end
        idle0(2, "rand_tail");

        chk("sweep_reset", 0, obs1(), model(3, 1, -100));
        rst1 = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            mask[s] = '0;
            cnt[s]  = 0;
        end
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk("sweep", c, obs1(), model(3, 1, c));
            if (c == 16) chk_val("sweep_done", {bus1.done, bus1.busy}, 2'b10);
            if (bus1.rd_valid === 1'b1 && bus1.stage < 3) begin
                mask[bus1.stage] = mask[bus1.stage] | (8'd1 << bus1.rd_addr_a)
                                                    | (8'd1 << bus1.rd_addr_b);
                cnt[bus1.stage]  = cnt[bus1.stage] + 2;
            end
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            chk_val("sweep_cover", {mask[s], 8'(cnt[s])}, {8'hFF, 8'd8});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
